// File: rtl/stage_if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Holds the bus/instruction widths, the NOP encoding substituted for faulted
// fetches, the fetch-buffer depth, the fetch-buffer entry layout and the
// fetch-control state encoding.
package stage_if_fetch_pkg;

    localparam int unsigned BUS_W    = 32;
    localparam int unsigned RVINST_W = 32;
    localparam int unsigned IF_BUF_D = 2;
    localparam int unsigned CNT_W    = $clog2(IF_BUF_D + 1);

    localparam logic [RVINST_W-1:0] INST_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [RVINST_W-1:0] inst;
        logic [BUS_W-1:0]    pc;
        logic                fault;
    } fetch_entry_t;

    // FS_FAULT: misaligned redirect seen, fault entry not yet queued.
    // FS_HALT : fault entry queued, no fetching until the next redirect.
    typedef enum logic [1:0] {
        FS_RUN,
        FS_FAULT,
        FS_HALT
    } fetch_state_t;

    function automatic logic is_misaligned(input logic [BUS_W-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/stage_if_fetch_fifo.sv
// Fetch_Fifo: small synchronous FIFO used for both the in-flight address queue
// and the fetch buffer of the fetch stage.
// Ports:
//   clk, rst        clock, synchronous active-high reset (empties the FIFO)
//   flush           empties the FIFO (takes priority over push/pop)
//   push, push_data write an entry; accepted when not full or when popping
//   pop, pop_data   remove the head entry; pop_data is the head (first-word
//                   fall-through)
//   count           current occupancy
module Fetch_Fifo #(
    parameter int unsigned W = 32,
    parameter int unsigned D = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             pop_data,
    output logic [$clog2(D+1)-1:0]   count
);

    localparam int unsigned PW = (D > 1) ? $clog2(D) : 1;
    localparam int unsigned CW = $clog2(D + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(D);
    localparam logic [PW-1:0] LAST_PTR = PW'(D - 1);

    logic [W-1:0]  mem [D];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    // Push into a full FIFO is allowed when the head leaves in the same cycle.
    assign do_pop  = pop && (cnt != '0);
    assign do_push = push && ((cnt != FULL_CNT) || do_pop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !(rst || flush)) mem[wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];
    assign count    = cnt;

endmodule

// File: rtl/stage_if_fetch.sv
// stage_if_fetch: instruction-fetch stage.
// Issues sequential word fetches to instruction memory, keeps at most two
// requests in flight, buffers responses for ID and handles redirects
// (flush + discard of stale responses) and misaligned redirect targets.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   imem_req_valid/ready        fetch request handshake
//   imem_addr                   fetch address (stable while valid, until accepted)
//   imem_rsp_valid/data/err     in-order responses, one per accepted request
//   redirect_valid/pc           single-cycle redirect from EX
//   id_valid/ready              instruction handshake towards ID
//   id_inst/id_pc/id_fault      head entry of the fetch buffer
module stage_if_fetch
    import stage_if_fetch_pkg::*;
#(
    parameter logic [BUS_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [BUS_W-1:0]    imem_addr,
    input  logic                imem_rsp_valid,
    input  logic [RVINST_W-1:0] imem_rsp_data,
    input  logic                imem_rsp_err,
    input  logic                redirect_valid,
    input  logic [BUS_W-1:0]    redirect_pc,
    output logic                id_valid,
    input  logic                id_ready,
    output logic [RVINST_W-1:0] id_inst,
    output logic [BUS_W-1:0]    id_pc,
    output logic                id_fault
);

    fetch_state_t     state;
    fetch_state_t     state_nxt;
    logic [BUS_W-1:0] pc;
    logic [1:0]       disc_cnt;

    logic [CNT_W-1:0] a_cnt;
    logic [CNT_W-1:0] b_cnt;
    logic [BUS_W-1:0] a_head;
    fetch_entry_t     b_head;
    fetch_entry_t     b_push_data;

    logic             req_hs;
    logic             rsp_any;
    logic             rsp_drop;
    logic             a_pop;
    logic             b_push;
    logic             id_pop;
    logic [2:0]       buf_load;
    logic [2:0]       out_after;

    // Outputs toward ID come straight from the buffer head.
    assign id_valid = !rst && (b_cnt != '0);
    assign id_inst  = b_head.inst;
    assign id_pc    = b_head.pc;
    assign id_fault = b_head.fault;
    assign imem_addr = pc;

    // ID pops are ignored in a redirect cycle: the buffer is being flushed.
    assign id_pop = id_valid && id_ready && !redirect_valid;

    // A response with nothing outstanding is ignored so the counters cannot wrap.
    assign rsp_any = imem_rsp_valid && ((a_cnt != '0) || (disc_cnt != 2'd0));

    // Buffer slots claimed = in-flight live requests + buffered entries, less
    // the entry ID takes this cycle; keeping this below the depth guarantees
    // every response has a slot without stalling zero-wait streaming.
    assign buf_load  = {1'b0, a_cnt} + {1'b0, b_cnt} - {2'b0, id_pop};
    // Requests still owned by memory (live + discarding) after this cycle's
    // response; also the new discard count when a redirect arrives.
    assign out_after = {1'b0, a_cnt} + {1'b0, disc_cnt} - {2'b0, rsp_any};

    assign req_hs   = imem_req_valid && imem_req_ready;
    assign rsp_drop = rsp_any && ((disc_cnt != 2'd0) || redirect_valid);
    assign a_pop    = rsp_any && !rsp_drop;
    assign b_push   = a_pop || ((state == FS_FAULT) && !redirect_valid);

    always_comb begin
        state_nxt      = state;
        imem_req_valid = 1'b0;
        if (redirect_valid) begin
            state_nxt = is_misaligned(redirect_pc) ? FS_FAULT : FS_RUN;
        end else begin
            case (state)
                FS_RUN: begin
                    imem_req_valid = !rst && (buf_load < 3'd2) && (out_after < 3'd2);
                end
                FS_FAULT: state_nxt = FS_HALT;
                FS_HALT:  state_nxt = FS_HALT;
                default:  state_nxt = FS_RUN;
            endcase
        end
    end

    always_comb begin
        b_push_data = '0;
        if (state == FS_FAULT) begin
            // pc still holds the misaligned redirect target.
            b_push_data.inst  = INST_NOP;
            b_push_data.pc    = pc;
            b_push_data.fault = 1'b1;
        end else begin
            b_push_data.inst  = imem_rsp_err ? INST_NOP : imem_rsp_data;
            b_push_data.pc    = a_head;
            b_push_data.fault = imem_rsp_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FS_RUN;
            pc       <= RESET_PC;
            disc_cnt <= 2'd0;
        end else begin
            state <= state_nxt;
            if (redirect_valid) begin
                pc       <= redirect_pc;
                disc_cnt <= out_after[1:0];
            end else begin
                if (req_hs)   pc       <= pc + 32'd4;
                if (rsp_drop) disc_cnt <= disc_cnt - 2'd1;
            end
        end
    end

    Fetch_Fifo #(
        .W (BUS_W),
        .D (IF_BUF_D)
    ) u_addr_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (req_hs),
        .push_data (pc),
        .pop       (a_pop),
        .pop_data  (a_head),
        .count     (a_cnt)
    );

    Fetch_Fifo #(
        .W ($bits(fetch_entry_t)),
        .D (IF_BUF_D)
    ) u_fetch_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (b_push),
        .push_data (b_push_data),
        .pop       (id_pop),
        .pop_data  (b_head),
        .count     (b_cnt)
    );

endmodule
